chan_err_inj: RTL
=================

# chan_err_inj

Parametrised channel error injector for the convolutional-code test path. It sits between the `encoder2` output and the `decoder` input and passes encoded symbols through with one cycle of latency. On selected symbols it XORs a programmable mask into the data, producing single errors or bursts that are either pseudo-random or periodic. It also keeps saturating statistics counters, so benches can correlate decoder output errors with the errors that were injected.

## Interface
Parameters:
- `SYM_W`, 2: symbol width in bits.
- `TRIG_BITS`, 5: number of LFSR low bits that must all be 1 to fire a random trigger (probability 2^-TRIG_BITS). Legal range is 1..16.
- `MAX_BURST`, 8: maximum burst length in symbols.
- `WINDOW`, 256: triggers are accepted only while `word_ct_o < WINDOW`.
- `SEED`, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-low.
- `mode_i`, in, 2: 00 = off (pass-through), 01 = random single, 10 = random burst, 11 = periodic burst.
- `burst_len_i`, in, $clog2(MAX_BURST+1): burst length in symbols. 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.
- `period_i`, in, 8: trigger period in valid symbols for mode 11. 0 means the mode never triggers.
- `err_mask_i`, in, SYM_W: XOR pattern applied to a corrupted symbol.
- `clr_i`, in, 1: synchronous clear of the counters and the window.
- `valid_i`, in, 1: input symbol is valid.
- `sym_i`, in, SYM_W: input symbol.
- `valid_o`, out, 1: registered copy of `valid_i`.
- `sym_o`, out, SYM_W: output symbol, corrupted or clean.
- `err_o`, out, 1: high when `sym_o` was corrupted this cycle.
- `inj_ct_o`, out, 16: count of corrupted symbols, saturating.
- `bit_ct_o`, out, 16: count of flipped bits, saturating.
- `word_ct_o`, out, 16: count of valid symbols seen, saturating.

## Operation
- **Datapath.** Every cycle, `sym_o <= sym_i ^ (corrupt ? err_mask_i : 0)` and `valid_o <= valid_i`. `corrupt` is only ever true when `valid_i` is high.
- **LFSR.** 16-bit Fibonacci LFSR with taps 16,14,13,11, shifting left and inserting the feedback at bit 0. It advances once per valid symbol. `clr_i` does not reset it.
- **Random trigger** (modes 01 and 10): `lfsr[TRIG_BITS-1:0] == all-ones`, evaluated on the current LFSR value before it advances.
- **Periodic trigger** (mode 11):
  - `per_ct` increments on each valid symbol and wraps to 0 after reaching `period_i-1`.
  - The trigger fires on the symbol where `per_ct == period_i-1`.
  - `per_ct` keeps counting during bursts.
  - `per_ct` is cleared by reset, by `clr_i`, and whenever `mode_i != 11`.
- **Gating.** A trigger is honoured only when `valid_i` is high, `word_ct_o < WINDOW`, and the FSM is in IDLE.
- **FSM states IDLE and BURST**, with remaining-length counter `rem`:
  - IDLE, honoured trigger, effective length L (forced to 1 in mode 01): the current symbol is corrupted. If L > 1, go to BURST with `rem = L-1`; otherwise stay in IDLE.
  - BURST, valid symbol: the symbol is corrupted and `rem` decrements. When `rem` reaches 0 the FSM returns to IDLE on the same edge.
  - BURST, invalid cycle: the FSM holds and nothing is corrupted.
  - Bursts are non-retriggerable. Triggers that occur during BURST are dropped.
  - A burst already in progress completes even after the window closes.
  - If `mode_i` is 00 the FSM is forced to IDLE immediately, aborting any burst.
  - Changing `burst_len_i` mid-burst has no effect; L is latched at the trigger.
- **Counters.** Each counter updates on the same edge as the corresponding output symbol and saturates at 16'hFFFF.
  - `word_ct_o` increments on each valid symbol.
  - `inj_ct_o` increments on each corrupted symbol.
  - `bit_ct_o` increases by `popcount(err_mask_i)` on each corrupted symbol.
  - `clr_i` zeroes all three and `per_ct`, and takes priority over any increment in the same cycle. The symbol presented in that cycle is still processed and may be corrupted.

## Timing
- Latency is one cycle from `sym_i`/`valid_i` to `sym_o`/`valid_o`/`err_o`.
- Reset values: `valid_o`=0, `sym_o`=0, `err_o`=0, all counters 0, FSM in IDLE, `rem`=0, `per_ct`=0, LFSR=SEED.
- Asserting reset mid-burst aborts the burst asynchronously. The first valid symbol after reset release passes through clean unless a fresh trigger fires on it.
- Window boundary: the symbol with index WINDOW-1 (`word_ct_o` = WINDOW-1 before the update) may still trigger. Symbol WINDOW cannot.
- `mode_i` and the other controls are sampled every cycle. No handshake is involved.

## Test plan
- **Pass-through.** Mode 00, 20 valid symbols 0,1,2,3 repeating. Expect `sym_o` equal to the input one cycle later, `err_o` never high, `inj_ct_o`=0, `word_ct_o`=20.
- **Periodic single.** Mode 11, `period_i`=4, `burst_len_i`=1, mask 2'b11, 12 valid symbols. Expect symbols 3, 7 and 11 (0-based) inverted, `inj_ct_o`=3, `bit_ct_o`=6.
- **Periodic burst with gap.** Mode 11, `period_i`=8, `burst_len_i`=3, mask 2'b01, 24 valid symbols, with `valid_i` low for 2 cycles after symbol 7. Expect symbols 7, 8, 9, 15, 16, 17 and 23 corrupted (the 23 burst is still in progress when the test ends). Expect no corruption in the invalid cycles and `bit_ct_o`=7.
- **Window and clamp.** WINDOW=4, mode 11, `period_i`=2, `burst_len_i`=0. Expect only symbols 1 and 3 corrupted out of 10, and `word_ct_o`=10.
- **Random single vs. model.** Mode 01, TRIG_BITS=2, SEED=16'hACE1, 256 symbols. Expect the corrupted positions to match a bench LFSR model exactly, and `inj_ct_o` equal to the model's trigger count.
- **Abort and reset.**
  - Mode 11, `period_i`=2, `burst_len_i`=8. Switch `mode_i` to 00 on the third symbol of the burst; expect no further corruption.
  - Repeat, but assert `rst` mid-burst instead. Expect all outputs 0 immediately and clean pass-through after release.

Source files
------------

// File: rtl/chan_err_inj.sv
// chan_err_inj
// ------------
// Channel error injector for the convolutional-code test path. Encoded
// symbols pass through with one cycle of latency. On selected symbols the
// programmable mask is XORed into the data, producing single errors or
// bursts that are either pseudo-random (LFSR driven) or periodic.
// Saturating counters record how many symbols were corrupted, how many bits
// were flipped and how many valid symbols were seen.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   mode_i       00 off, 01 random single, 10 random burst, 11 periodic burst
//   burst_len_i  burst length in symbols (0 -> 1, clamped to MAX_BURST)
//   period_i     trigger period in valid symbols for mode 11 (0 = never)
//   err_mask_i   XOR pattern applied to a corrupted symbol
//   clr_i        synchronous clear of counters and the trigger window
//   valid_i      input symbol valid
//   sym_i        input symbol
//   valid_o      registered valid_i
//   sym_o        output symbol, corrupted or clean
//   err_o        sym_o was corrupted this cycle
//   inj_ct_o     corrupted symbol count (saturating)
//   bit_ct_o     flipped bit count (saturating)
//   word_ct_o    valid symbol count (saturating); also defines the window
module chan_err_inj #(
    parameter int          SYM_W     = 2,
    parameter int          TRIG_BITS = 5,
    parameter int          MAX_BURST = 8,
    parameter int          WINDOW    = 256,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       mode_i,
    input  logic [$clog2(MAX_BURST+1)-1:0]   burst_len_i,
    input  logic [7:0]                       period_i,
    input  logic [SYM_W-1:0]                 err_mask_i,
    input  logic                             clr_i,
    input  logic                             valid_i,
    input  logic [SYM_W-1:0]                 sym_i,
    output logic                             valid_o,
    output logic [SYM_W-1:0]                 sym_o,
    output logic                             err_o,
    output logic [15:0]                      inj_ct_o,
    output logic [15:0]                      bit_ct_o,
    output logic [15:0]                      word_ct_o
);

    localparam int                   LEN_W     = $clog2(MAX_BURST + 1);
    localparam int                   POP_W     = $clog2(SYM_W + 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0]          SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [LEN_W-1:0]     MAX_LEN   = LEN_W'(MAX_BURST);
    localparam logic [LEN_W-1:0]     ONE_LEN   = LEN_W'(1);
    localparam logic [TRIG_BITS-1:0] TRIG_ONES = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic [15:0]      lfsr;
    logic [7:0]       per_ct;

    logic             lfsr_fb;
    logic             rand_trig;
    logic             per_wrap;
    logic             per_trig;
    logic             in_window;
    logic             fire;
    logic             corrupt;
    logic [LEN_W-1:0] eff_len;
    logic [POP_W-1:0] mask_pop;
    logic [16:0]      word_sum;
    logic [16:0]      inj_sum;
    logic [16:0]      bit_sum;

    // Trigger qualification, effective burst length and the corrupt decision
    // for the symbol currently on the input. The random trigger looks at the
    // LFSR value before it advances on this symbol.
    always_comb begin
        lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        rand_trig = ((mode_i == 2'b01) || (mode_i == 2'b10)) &&
                    (lfsr[TRIG_BITS-1:0] == TRIG_ONES);
        per_wrap  = (per_ct == (period_i - 8'd1));
        per_trig  = (mode_i == 2'b11) && (period_i != 8'd0) && per_wrap;
        in_window = ({16'd0, word_ct_o} < 32'(WINDOW));
        fire      = valid_i && in_window && (state == IDLE) && (rand_trig || per_trig);

        // Random-single mode always uses a length of one.
        if ((mode_i == 2'b01) || (burst_len_i == '0)) begin
            eff_len = ONE_LEN;
        end else if (burst_len_i > MAX_LEN) begin
            eff_len = MAX_LEN;
        end else begin
            eff_len = burst_len_i;
        end

        // Mode 00 aborts a running burst in the same cycle.
        corrupt = (mode_i != 2'b00) && valid_i && ((state == BURST) || fire);

        mask_pop = '0;
        for (int i = 0; i < SYM_W; i++) begin
            mask_pop = mask_pop + POP_W'(err_mask_i[i]);
        end

        word_sum = {1'b0, word_ct_o} + 17'd1;
        inj_sum  = {1'b0, inj_ct_o} + 17'd1;
        bit_sum  = {1'b0, bit_ct_o} + 17'(mask_pop);
    end

    // Datapath register, LFSR, burst FSM, period counter and statistics.
    // clr_i only affects the counters and per_ct; the symbol in that cycle is
    // still processed normally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o   <= 1'b0;
            sym_o     <= '0;
            err_o     <= 1'b0;
            inj_ct_o  <= 16'd0;
            bit_ct_o  <= 16'd0;
            word_ct_o <= 16'd0;
            state     <= IDLE;
            rem       <= '0;
            per_ct    <= 8'd0;
            lfsr      <= SEED_EFF;
        end else begin
            valid_o <= valid_i;
            sym_o   <= corrupt ? (sym_i ^ err_mask_i) : sym_i;
            err_o   <= corrupt;

            if (valid_i) begin
                lfsr <= {lfsr[14:0], lfsr_fb};
            end

            if (mode_i == 2'b00) begin
                state <= IDLE;
                rem   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fire && (eff_len > ONE_LEN)) begin
                            state <= BURST;
                            rem   <= eff_len - ONE_LEN;
                        end
                    end
                    BURST: begin
                        if (valid_i) begin
                            rem <= rem - ONE_LEN;
                            if (rem == ONE_LEN) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        rem   <= '0;
                    end
                endcase
            end

            // per_ct keeps running through bursts so the period stays exact.
            if (clr_i || (mode_i != 2'b11)) begin
                per_ct <= 8'd0;
            end else if (valid_i) begin
                per_ct <= ((period_i != 8'd0) && per_wrap) ? 8'd0 : per_ct + 8'd1;
            end

            if (clr_i) begin
                word_ct_o <= 16'd0;
                inj_ct_o  <= 16'd0;
                bit_ct_o  <= 16'd0;
            end else begin
                if (valid_i) begin
                    word_ct_o <= word_sum[16] ? 16'hFFFF : word_sum[15:0];
                end
                if (corrupt) begin
                    inj_ct_o <= inj_sum[16] ? 16'hFFFF : inj_sum[15:0];
                    bit_ct_o <= bit_sum[16] ? 16'hFFFF : bit_sum[15:0];
                end
            end
        end
    end

endmodule
